// File: rtl/instr_encode_loader.sv
// Program loader: encodes decoded instruction fields into MIPS words and streams them into
// instruction memory while holding the core in reset. Define NOP_PAD_EN to zero-fill after halt.
module instr_encode_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_funct_sel,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              error,
    output logic              cpu_rst_n
);

`ifdef NOP_PAD_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
`endif

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
`ifdef NOP_PAD_EN
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
`endif

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic [5:0]          funct;
    logic                funct_bad;
    logic                kind_bad;
    logic                is_halt;
    logic [31:0]         enc_word;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        funct     = 6'b000000;
        funct_bad = 1'b0;
        case (in_funct_sel)
            3'd0:    funct = 6'b100000;
            3'd1:    funct = 6'b100010;
            3'd2:    funct = 6'b101010;
            3'd3:    funct = 6'b011100;
            3'd4:    funct = 6'b100100;
            3'd5:    funct = 6'b100101;
            default: funct_bad = 1'b1;
        endcase
    end

    always_comb begin
        enc_word = 32'h0000_0000;
        kind_bad = 1'b0;
        is_halt  = 1'b0;
        case (in_kind)
            3'd0:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
            3'd1:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
            3'd2: begin
                enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, funct};
                kind_bad = funct_bad;
            end
            3'd3:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
            3'd4:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
            3'd5:    enc_word = {6'b000010, in_target};
            3'd6:    is_halt  = 1'b1;
            default: kind_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    if (kind_bad) begin
                        state_d = S_ERR;
                    end else if (is_halt) begin
`ifdef NOP_PAD_EN
                        state_d = (count_q == FULL_CNT) ? S_DONE : S_PAD;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = count_q[ADDR_W-1:0];
                        mem_wdata_d = enc_word;
                        count_d     = count_q + (ADDR_W+1)'(1);
                        if (count_q == LAST_CNT) state_d = S_DONE;
                    end
                end
            end
`ifdef NOP_PAD_EN
            // Zero words decode as sll $0,$0,0, i.e. a NOP for the core.
            S_PAD: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = count_q[ADDR_W-1:0];
                mem_wdata_d = 32'h0000_0000;
                count_d     = count_q + (ADDR_W+1)'(1);
                if (count_q == LAST_CNT) state_d = S_DONE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign cpu_rst_n = (state_q == S_DONE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a 64-deep instance for the main flow and a 4-deep
// instance for fill and short-program cases; expected writes go through per-instance queues.
module tb_instr_encode_loader;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  fsel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, valid_a, valid_b;
    logic [2:0]  kind, fsel;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;

    logic        ready_a, we_a, done_a, err_a, cpu_a;
    logic [5:0]  addr_a;
    logic [31:0] wdata_a;
    logic [6:0]  count_a;

    logic        ready_b, we_b, done_b, err_b, cpu_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    int total = 0;
    int bad   = 0;
    wr_t q_a[$];
    wr_t q_b[$];
    step_t burst[5];

    always #5 clk = ~clk;

    instr_encode_loader #(.DEPTH(64), .ADDR_W(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
        .in_kind(kind), .in_funct_sel(fsel), .in_rs(rs), .in_rt(rt), .in_rd(rd),
        .in_imm(imm), .in_target(tgt), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .count(count_a), .done(done_a), .error(err_a),
        .cpu_rst_n(cpu_a)
    );

    instr_encode_loader #(.DEPTH(4), .ADDR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_kind(kind), .in_funct_sel(fsel), .in_rs(rs), .in_rt(rt), .in_rd(rd),
        .in_imm(imm), .in_target(tgt), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .count(count_b), .done(done_b), .error(err_b),
        .cpu_rst_n(cpu_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_f(input step_t s);
        kind = s.kind; fsel = s.fsel; rs = s.rs; rt = s.rt; rd = s.rd;
        imm = s.imm; tgt = s.tgt;
    endtask

    task automatic push_a(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = 6'(a);
        e.data = d;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = 6'(a);
        e.data = d;
        q_b.push_back(e);
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (done_a !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, done_a, 1'b1);
    endtask

    task automatic wait_done_b(input string tag);
        int n = 0;
        while (done_b !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(tag, done_b, 1'b1);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (we_a === 1'b1) begin
            if (q_a.size() == 0) check("a_spurious_we", we_a, 1'b0);
            else begin
                e = q_a.pop_front();
                check("a_wr_addr", addr_a, e.addr);
                check("a_wr_data", wdata_a, e.data);
            end
        end
        if (we_b === 1'b1) begin
            if (q_b.size() == 0) check("b_spurious_we", we_b, 1'b0);
            else begin
                e = q_b.pop_front();
                check("b_wr_addr", addr_b, e.addr);
                check("b_wr_data", wdata_b, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step_t s_lw, s_halt, s_add, s_ill, s_rbad, s_addi, s_sw;
        s_lw   = '{3'd0, 3'd0, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 32'h8C430010};
        s_halt = '{3'd6, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0,    26'h0, 32'h0};
        s_add  = '{3'd2, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0,    26'h0, 32'h00221820};
        s_ill  = '{3'd7, 3'd0, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 32'h0};
        s_rbad = '{3'd2, 3'd6, 5'd1, 5'd2, 5'd3, 16'h0,    26'h0, 32'h0};
        s_addi = '{3'd3, 3'd0, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0, 32'h20220005};
        s_sw   = '{3'd1, 3'd0, 5'd4, 5'd5, 5'd0, 16'h0008, 26'h0, 32'hAC850008};
        burst[0] = s_add;
        burst[1] = '{3'd2, 3'd3, 5'd1, 5'd2, 5'd3, 16'h0,    26'h0,  32'h0022181C};
        burst[2] = '{3'd4, 3'd0, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0,  32'h1022FFFF};
        burst[3] = '{3'd5, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0,    26'h10, 32'h08000010};
        burst[4] = s_halt;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        set_f(s_halt);
        repeat (2) tick();
        check("rst_ready", ready_a, 1'b0);
        check("rst_we", we_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_error", err_a, 1'b0);
        check("rst_cpu_rst_n", cpu_a, 1'b0);
        check("rst_count", count_a, 7'd0);
        check("rst_addr", addr_a, 6'd0);
        check("rst_wdata", wdata_a, 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", ready_a, 1'b0);

        // Session 1: single lw then halt.
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("load_ready", ready_a, 1'b1);
        set_f(s_lw); push_a(0, s_lw.exp);
        valid_a = 1'b1; tick(); valid_a = 1'b0;
        check("lw_we", we_a, 1'b1);
        check("lw_count", count_a, 7'd1);
        set_f(s_halt);
`ifdef NOP_PAD_EN
        for (int i = 1; i < 64; i++) push_a(i, 32'h0);
`endif
        valid_a = 1'b1; tick(); valid_a = 1'b0;
        check("halt1_ready", ready_a, 1'b0);
        wait_done_a("halt1_done");

        // Session 2: back-to-back burst ending in halt.
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("s2_done_clear", done_a, 1'b0);
        check("s2_count_clear", count_a, 7'd0);
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_f(burst[i]);
            if (burst[i].kind != 3'd6) push_a(i, burst[i].exp);
`ifdef NOP_PAD_EN
            else for (int j = 4; j < 64; j++) push_a(j, 32'h0);
`endif
            tick();
            if (burst[i].kind != 3'd6) check("burst_we", we_a, 1'b1);
        end
        valid_a = 1'b0;
        check("burst_ready_drop", ready_a, 1'b0);
        wait_done_a("burst_done");
        check("burst_cpu_rst_n", cpu_a, 1'b1);
`ifdef NOP_PAD_EN
        check("burst_count", count_a, 7'd64);
`else
        check("burst_count", count_a, 7'd4);
`endif

        // Illegal kind, then illegal funct, then recovery.
        start_a = 1'b1; tick(); start_a = 1'b0;
        set_f(s_ill); valid_a = 1'b1; tick(); valid_a = 1'b0;
        check("ill_we", we_a, 1'b0);
        check("ill_error", err_a, 1'b1);
        check("ill_cpu_rst_n", cpu_a, 1'b0);
        check("ill_ready", ready_a, 1'b0);
        check("ill_done", done_a, 1'b0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("ill_err_clear", err_a, 1'b0);
        check("ill_restart_ready", ready_a, 1'b1);
        set_f(s_rbad); valid_a = 1'b1; tick(); valid_a = 1'b0;
        check("rbad_error", err_a, 1'b1);
        check("rbad_we", we_a, 1'b0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("rbad_err_clear", err_a, 1'b0);
        set_f(s_addi); push_a(0, s_addi.exp);
        valid_a = 1'b1; tick(); valid_a = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("start_in_load_ready", ready_a, 1'b1);
        set_f(s_sw); push_a(1, s_sw.exp);
        valid_a = 1'b1; tick(); valid_a = 1'b0;
        check("two_words_count", count_a, 7'd2);

        // Reset mid-stream with a handshake and a start in the same cycle.
        set_f(s_add); valid_a = 1'b1; start_a = 1'b1; rst_n = 1'b0;
        tick();
        check("mid_rst_count", count_a, 7'd0);
        check("mid_rst_we", we_a, 1'b0);
        check("mid_rst_cpu_rst_n", cpu_a, 1'b0);
        check("mid_rst_ready", ready_a, 1'b0);
        rst_n = 1'b1; start_a = 1'b0;
        tick();
        check("post_rst_we", we_a, 1'b0);
        check("post_rst_ready", ready_a, 1'b0);
        check("post_rst_count", count_a, 7'd0);
        valid_a = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        set_f(s_lw); push_a(0, s_lw.exp);
        valid_a = 1'b1; tick(); valid_a = 1'b0;
        check("resume_count", count_a, 7'd1);

        // Small instance: fill to DEPTH with no halt.
        start_b = 1'b1; tick(); start_b = 1'b0;
        set_f(s_add); valid_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_b(i, s_add.exp);
            tick();
            check("fill_we", we_b, 1'b1);
        end
        check("fill_done_with_last_we", done_b, 1'b1);
        check("fill_cpu_rst_n", cpu_b, 1'b1);
        tick();
        valid_b = 1'b0;
        check("fill_fifth_we", we_b, 1'b0);
        check("fill_ready", ready_b, 1'b0);
        check("fill_count", count_b, 3'd4);

        // Small instance: two words then halt.
        start_b = 1'b1; tick(); start_b = 1'b0;
        valid_b = 1'b1;
        set_f(s_lw); push_b(0, s_lw.exp); tick();
        set_f(s_add); push_b(1, s_add.exp); tick();
        set_f(s_halt);
`ifdef NOP_PAD_EN
        push_b(2, 32'h0); push_b(3, 32'h0);
`endif
        tick();
        valid_b = 1'b0;
        check("short_ready", ready_b, 1'b0);
        wait_done_b("short_done");
`ifdef NOP_PAD_EN
        check("short_count", count_b, 3'd4);
`else
        check("short_count", count_b, 3'd2);
`endif

        repeat (3) tick();
        check("a_queue_drained", 64'(q_a.size()), 64'd0);
        check("b_queue_drained", 64'(q_b.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
